// File: rtl/forward_pkg.sv
// Shared types and helpers for the operand forwarding / load-use hazard unit.
// The rd field is sized for the widest supported register number; narrower ports zero-extend.
package forward_pkg;

   localparam int REG_NUM_WIDTH_MAX = 8;
   localparam int FWD_SEL_REGFILE   = 0;

   typedef struct packed {
      logic                         valid;
      logic [REG_NUM_WIDTH_MAX-1:0] rd;
      logic                         wr;
      logic                         wr_r0;
      logic                         load;
   } fwd_tag_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

   // An in-flight write produces rn if it names rn explicitly, or implicitly writes R0 and rn is R0.
   function automatic logic tag_matches(input fwd_tag_t tag, input logic [REG_NUM_WIDTH_MAX-1:0] rn);
      return tag.valid && ((tag.wr && (tag.rd == rn)) || (tag.wr_r0 && (rn == '0)));
   endfunction

endpackage

// File: rtl/fwd_source_select.sv
// Per-operand forwarding select: youngest matching stage wins, plus its load-use flag.
module fwd_source_select
   import forward_pkg::*;
#(
   parameter int REG_NUM_WIDTH     = 4,
   parameter int NUM_STAGES        = 3,
   parameter int REG_FORWARD_WIDTH = 2,
   parameter int LOAD_LATENCY      = 1
) (
   input  fwd_tag_t [NUM_STAGES:1]      i_tags,
   input  logic [REG_NUM_WIDTH-1:0]     i_rn,
   input  logic                         i_use_rn,
   output logic [REG_FORWARD_WIDTH-1:0] o_sel,
   output logic                         o_load_hit
);

   logic [REG_NUM_WIDTH_MAX-1:0] w_rn;

   assign w_rn = REG_NUM_WIDTH_MAX'(i_rn);

   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   // Scanning oldest to youngest lets the lowest matching stage overwrite the older ones.
   always_comb begin
      o_sel      = REG_FORWARD_WIDTH'(FWD_SEL_REGFILE);
      o_load_hit = 1'b0;
      if (i_use_rn) begin
         for (int k = NUM_STAGES; k >= 1; k--) begin
            if (tag_matches(i_tags[k], w_rn)) begin
               o_sel      = REG_FORWARD_WIDTH'(k);
               o_load_hit = i_tags[k].load && (k <= LOAD_LATENCY);
            end
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Decode-stage tag pipeline for operand forwarding and load-use stalls.
// Optional FWD_STATS_EN adds saturating stall_count / fwd_count statistics outputs.
module forward_scoreboard
   import forward_pkg::*;
#(
   parameter int REG_NUM_WIDTH     = 4,
   parameter int NUM_STAGES        = 3,
   parameter int REG_FORWARD_WIDTH = 2,
   parameter int LOAD_LATENCY      = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [REG_NUM_WIDTH-1:0]     rn_1,
   input  logic [REG_NUM_WIDTH-1:0]     rn_2,
   input  logic                         use_rn_1,
   input  logic                         use_rn_2,
   input  logic                         issue_valid,
   input  logic [REG_NUM_WIDTH-1:0]     issue_rd,
   input  logic                         issue_wr,
   input  logic                         issue_wr_r0,
   input  logic                         issue_load,
   input  logic                         flush,
   output logic [REG_FORWARD_WIDTH-1:0] fwd_sel_1,
   output logic [REG_FORWARD_WIDTH-1:0] fwd_sel_2,
   output logic                         stall
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]                  stall_count,
   output logic [31:0]                  fwd_count
`endif
);

   if (REG_FORWARD_WIDTH < clog2(NUM_STAGES + 1) || REG_NUM_WIDTH > REG_NUM_WIDTH_MAX ||
       NUM_STAGES < 1 || NUM_STAGES > 7 || LOAD_LATENCY >= NUM_STAGES) begin : g_param_check
      $error("forward_scoreboard: illegal parameter combination");
   end

   fwd_tag_t [NUM_STAGES:1] r_tags;
   fwd_tag_t                w_issue_tag;
   logic                    w_issue_accept;
   logic                    w_load_hit_1;
   logic                    w_load_hit_2;

   assign w_issue_tag    = '{valid: 1'b1, rd: REG_NUM_WIDTH_MAX'(issue_rd), wr: issue_wr,
                             wr_r0: issue_wr_r0, load: issue_load};
   assign w_issue_accept = issue_valid && !stall && !flush;
   assign stall          = issue_valid && (w_load_hit_1 || w_load_hit_2);

   // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tags <= '0;
      end else if (flush) begin
         r_tags <= '0;
      end else begin
         r_tags[1] <= w_issue_accept ? w_issue_tag : '0;
         for (int k = 2; k <= NUM_STAGES; k++) begin
            r_tags[k] <= r_tags[k-1];
         end
      end
   end

   fwd_source_select #(
      .REG_NUM_WIDTH    (REG_NUM_WIDTH),
      .NUM_STAGES       (NUM_STAGES),
      .REG_FORWARD_WIDTH(REG_FORWARD_WIDTH),
      .LOAD_LATENCY     (LOAD_LATENCY)
   ) u_sel_1 (
      .i_tags    (r_tags),
      .i_rn      (rn_1),
      .i_use_rn  (use_rn_1),
      .o_sel     (fwd_sel_1),
      .o_load_hit(w_load_hit_1)
   );

   fwd_source_select #(
      .REG_NUM_WIDTH    (REG_NUM_WIDTH),
      .NUM_STAGES       (NUM_STAGES),
      .REG_FORWARD_WIDTH(REG_FORWARD_WIDTH),
      .LOAD_LATENCY     (LOAD_LATENCY)
   ) u_sel_2 (
      .i_tags    (r_tags),
      .i_rn      (rn_2),
      .i_use_rn  (use_rn_2),
      .o_sel     (fwd_sel_2),
      .o_load_hit(w_load_hit_2)
   );

`ifdef FWD_STATS_EN
   logic [31:0] r_stall_count;
   logic [31:0] r_fwd_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
         r_fwd_count   <= '0;
      end else begin
         if (stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
         if (((fwd_sel_1 != '0) || (fwd_sel_2 != '0)) && (r_fwd_count != '1)) begin
            r_fwd_count <= r_fwd_count + 32'd1;
         end
      end
   end

   assign stall_count = r_stall_count;
   assign fwd_count   = r_fwd_count;
`endif

endmodule
